// File: rtl/uncached_bus_master_if.sv
// Shared wired-OR system bus as seen by one single-beat master.
// The master modport drives the beat signals; the slave modport is the arbiter/slave side.
interface uncached_bus_master_if;
  logic        requestBus;
  logic        busAccessGranted;
  logic        beginTransactionOut;
  logic [31:0] addressDataOut;
  logic [3:0]  byteEnablesOut;
  logic        readNotWriteOut;
  logic [7:0]  burstSizeOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busyIn;
  logic        dataValidIn;
  logic [31:0] addressDataIn;
  logic        endTransactionIn;
  logic        busErrorIn;

  modport master (
    output requestBus, beginTransactionOut, addressDataOut, byteEnablesOut,
           readNotWriteOut, burstSizeOut, dataValidOut, endTransactionOut,
    input  busAccessGranted, busyIn, dataValidIn, addressDataIn,
           endTransactionIn, busErrorIn
  );

  modport slave (
    input  requestBus, beginTransactionOut, addressDataOut, byteEnablesOut,
           readNotWriteOut, burstSizeOut, dataValidOut, endTransactionOut,
    output busAccessGranted, busyIn, dataValidIn, addressDataIn,
           endTransactionIn, busErrorIn
  );
endinterface

// File: rtl/uncached_bus_master.sv
// Single-beat bus master for uncached loads/stores: arbitrates, runs one read or
// write transaction on the wired-OR bus and reports data or error with a done pulse.
module uncached_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  startIn,
  input  logic                  readNotWriteIn,
  input  logic [31:0]           addressIn,
  input  logic [31:0]           writeDataIn,
  input  logic [3:0]            byteEnablesIn,
  output logic                  busyOut,
  output logic                  doneOut,
  output logic                  errorOut,
  output logic [31:0]           readDataOut,
  uncached_bus_master_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_BEGIN,
    ST_WRITE_DATA,
    ST_END,
    ST_WAIT_READ,
    ST_WAIT_END,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        rnw_q, rnw_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        tmo_err_q, tmo_err_d;
  logic        tmo_hit;

  // Counter holds (cycles since the begin beat - 1); firing here puts ERROR
  // exactly TIMEOUT_CYCLES cycles after the begin beat.
  assign tmo_hit = ({1'b0, tmo_cnt_q} + 9'd2) >= 9'(TIMEOUT_CYCLES);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rnw_d     = rnw_q;
    rdata_d   = rdata_q;
    tmo_cnt_d = tmo_cnt_q;
    tmo_err_d = tmo_err_q;
    case (state_q)
      ST_IDLE: begin
        if (startIn) begin
          addr_d  = addressIn;
          wdata_d = writeDataIn;
          be_d    = byteEnablesIn;
          rnw_d   = readNotWriteIn;
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (bus.busAccessGranted) state_d = ST_BEGIN;
      end
      ST_BEGIN: begin
        tmo_cnt_d = '0;
        if (bus.busErrorIn) begin
          state_d   = ST_ERROR;
          tmo_err_d = 1'b0;
        end else if (rnw_q) begin
          state_d = ST_WAIT_READ;
        end else begin
          state_d = ST_WRITE_DATA;
        end
      end
      ST_WRITE_DATA, ST_WAIT_READ, ST_WAIT_END: begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
        // Errors win over any simultaneous handshake from the slave.
        if (bus.busErrorIn) begin
          state_d   = ST_ERROR;
          tmo_err_d = 1'b0;
        end else if (tmo_hit) begin
          state_d   = ST_ERROR;
          tmo_err_d = 1'b1;
        end else if (state_q == ST_WRITE_DATA) begin
          if (!bus.busyIn) state_d = ST_END;
        end else if (state_q == ST_WAIT_END) begin
          if (bus.endTransactionIn) state_d = ST_DONE;
        end else if (bus.dataValidIn) begin
          rdata_d = bus.addressDataIn;
          state_d = bus.endTransactionIn ? ST_DONE : ST_WAIT_END;
        end else if (bus.endTransactionIn) begin
          // Slave ended a read without data; it already closed the bus.
          state_d   = ST_ERROR;
          tmo_err_d = 1'b0;
        end
      end
      ST_END:             state_d = ST_DONE;
      ST_DONE, ST_ERROR:  state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rdata_q   <= '0;
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  // Request fields are only consumed after IDLE has latched them.
  always_ff @(posedge clock) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    rnw_q   <= rnw_d;
  end

  assign busyOut     = (state_q != ST_IDLE);
  assign doneOut     = (state_q == ST_DONE) || (state_q == ST_ERROR);
  assign errorOut    = (state_q == ST_ERROR);
  assign readDataOut = rdata_q;

  // Wired-OR bus: every field is forced to zero outside its own beat.
  assign bus.requestBus          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.beginTransactionOut = (state_q == ST_BEGIN);
  assign bus.addressDataOut      = (state_q == ST_BEGIN)      ? addr_q  :
                                   (state_q == ST_WRITE_DATA) ? wdata_q : 32'd0;
  assign bus.byteEnablesOut      = (state_q == ST_BEGIN) ? be_q : 4'd0;
  assign bus.readNotWriteOut     = (state_q == ST_BEGIN) && rnw_q;
  assign bus.burstSizeOut        = 8'd0;
  assign bus.dataValidOut        = (state_q == ST_WRITE_DATA);
  assign bus.endTransactionOut   = (state_q == ST_END) || ((state_q == ST_ERROR) && tmo_err_q);

endmodule

// File: tb/tb_uncached_bus_master.sv
// Bench for uncached_bus_master: two instances (long and short timeout) share one
// randomized stimulus stream and are checked cycle by cycle against a timeline model.
module tb_uncached_bus_master;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        startIn, readNotWriteIn;
  logic [31:0] addressIn, writeDataIn;
  logic [3:0]  byteEnablesIn;
  logic        gnt, bsy, dvin, endin, berr;
  logic [31:0] adin;

  logic        busy_a, done_a, error_a, busy_b, done_b, error_b;
  logic [31:0] rdata_a, rdata_b;

  uncached_bus_master_if bus_a ();
  uncached_bus_master_if bus_b ();

  assign bus_a.busAccessGranted = gnt;
  assign bus_a.busyIn           = bsy;
  assign bus_a.dataValidIn      = dvin;
  assign bus_a.addressDataIn    = adin;
  assign bus_a.endTransactionIn = endin;
  assign bus_a.busErrorIn       = berr;
  assign bus_b.busAccessGranted = gnt;
  assign bus_b.busyIn           = bsy;
  assign bus_b.dataValidIn      = dvin;
  assign bus_b.addressDataIn    = adin;
  assign bus_b.endTransactionIn = endin;
  assign bus_b.busErrorIn       = berr;

  uncached_bus_master #(.TIMEOUT_CYCLES(255)) dut_a (
    .clock(clock), .reset(reset), .startIn(startIn), .readNotWriteIn(readNotWriteIn),
    .addressIn(addressIn), .writeDataIn(writeDataIn), .byteEnablesIn(byteEnablesIn),
    .busyOut(busy_a), .doneOut(done_a), .errorOut(error_a), .readDataOut(rdata_a),
    .bus(bus_a)
  );

  uncached_bus_master #(.TIMEOUT_CYCLES(4)) dut_b (
    .clock(clock), .reset(reset), .startIn(startIn), .readNotWriteIn(readNotWriteIn),
    .addressIn(addressIn), .writeDataIn(writeDataIn), .byteEnablesIn(byteEnablesIn),
    .busyOut(busy_b), .doneOut(done_b), .errorOut(error_b), .readDataOut(rdata_b),
    .bus(bus_b)
  );

  logic [63:0] obs_a, obs_b;
  assign obs_a = {12'd0, busy_a, done_a, error_a, bus_a.requestBus, bus_a.beginTransactionOut,
                  bus_a.dataValidOut, bus_a.endTransactionOut, bus_a.readNotWriteOut,
                  bus_a.byteEnablesOut, bus_a.burstSizeOut, bus_a.addressDataOut};
  assign obs_b = {12'd0, busy_b, done_b, error_b, bus_b.requestBus, bus_b.beginTransactionOut,
                  bus_b.dataValidOut, bus_b.endTransactionOut, bus_b.readNotWriteOut,
                  bus_b.byteEnablesOut, bus_b.burstSizeOut, bus_b.addressDataOut};

  typedef struct {
    bit          wr;
    int          gd;      // extra REQUEST cycles before grant
    int          busy;    // write: busyIn cycles
    int          rd;      // read: WAIT_READ cycles before data
    int          gap;     // read: cycles from data to slave end (0 = same cycle)
    bit          has_err;
    int          e;       // busErrorIn at begin + e
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
  } txn_t;

  typedef struct {
    int B, c, d, x, D;
    bit err, tmo, cap;
  } res_t;

  int          n_tests, n_fail;
  logic [31:0] shadow_a, shadow_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Timeline of one transaction, in cycles relative to the start cycle (r = 0).
  function automatic res_t model(input txn_t t, input int T);
    res_t m;
    int   eb, f;
    bit   ebv, fv;
    m.B = 2 + t.gd;
    m.d = 0;
    if (t.wr) m.c = m.B + 1 + t.busy;
    else begin
      m.d = m.B + 1 + t.rd;
      m.c = m.d + t.gap;
    end
    eb  = m.B + t.e;
    ebv = t.has_err && (eb <= m.c);
    f   = m.B + ((T >= 2) ? T - 1 : 1);
    fv  = (f <= m.c);
    m.err = 0; m.tmo = 0; m.x = 0;
    if (ebv && (!fv || eb <= f)) begin
      m.err = 1; m.x = eb;
    end else if (fv) begin
      m.err = 1; m.tmo = 1; m.x = f;
    end
    if (m.err)     m.D = m.x + 1;
    else if (t.wr) m.D = m.c + 2;
    else           m.D = m.c + 1;
    m.cap = !t.wr && (!m.err || m.d < m.x);
    return m;
  endfunction

  function automatic logic [63:0] exp_vec(input txn_t t, input res_t m, input int r);
    logic busy, done, err, req, beg, dv, en, rnw;
    logic [3:0]  be;
    logic [31:0] ad;
    int          wlast;
    busy  = (r >= 1 && r <= m.D);
    done  = (r == m.D);
    err   = done && m.err;
    req   = (r >= 1 && r < m.D) || (r == m.D && m.err);
    beg   = (r == m.B);
    wlast = m.err ? m.x : m.c;
    dv    = t.wr && r >= m.B + 1 && r <= wlast;
    en    = (t.wr && !m.err && r == m.c + 1) || (m.err && m.tmo && r == m.x + 1);
    rnw   = beg && !t.wr;
    be    = beg ? t.be : 4'd0;
    ad    = beg ? t.addr : (dv ? t.wdata : 32'd0);
    return {12'd0, busy, done, err, req, beg, dv, en, rnw, be, 8'd0, ad};
  endfunction

  function automatic txn_t mk_txn(input bit wr, input int gd, input int busy, input int rd,
                                  input int gap, input bit he, input int e,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rdv, input logic [3:0] be);
    txn_t t;
    t.wr = wr; t.gd = gd; t.busy = busy; t.rd = rd; t.gap = gap;
    t.has_err = he; t.e = e; t.addr = a; t.wdata = wd; t.rdata = rdv; t.be = be;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.wr      = 1'($urandom_range(0, 1));
    t.gd      = int'($urandom_range(0, 3));
    t.busy    = int'($urandom_range(0, 4));
    t.rd      = int'($urandom_range(0, 4));
    t.gap     = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
    t.has_err = ($urandom_range(0, 4) == 0);
    t.e       = int'($urandom_range(0, 6));
    t.addr    = $urandom() & 32'hFFFF_FFFC;
    t.wdata   = $urandom();
    t.rdata   = $urandom();
    t.be      = 4'($urandom_range(1, 15));
    return t;
  endfunction

  task automatic idle_inputs();
    startIn = 1'b0; readNotWriteIn = 1'b0; addressIn = '0; writeDataIn = '0; byteEnablesIn = '0;
    gnt = 1'b0; bsy = 1'b0; dvin = 1'b0; endin = 1'b0; berr = 1'b0; adin = '0;
  endtask

  // Drives one transaction to both instances; rst_at >= 0 pulses reset in that cycle.
  task automatic run_txn(input txn_t t, input int rst_at);
    res_t        ma, mb;
    int          last, dmin;
    logic [31:0] ra, rb;
    ma   = model(t, 255);
    mb   = model(t, 4);
    last = ((ma.D > mb.D) ? ma.D : mb.D) + 1;
    dmin = (ma.D < mb.D) ? ma.D : mb.D;
    ra   = ma.cap ? t.rdata : shadow_a;
    rb   = mb.cap ? t.rdata : shadow_b;
    for (int r = 0; r <= last; r++) begin
      reset = (r == rst_at);
      if (r == 0) begin
        startIn = 1'b1; readNotWriteIn = !t.wr; addressIn = t.addr;
        writeDataIn = t.wdata; byteEnablesIn = t.be;
      end else begin
        startIn = (r < dmin) && (rst_at < 0 || r < rst_at) &&
                  (r == 2 || $urandom_range(0, 2) == 0);
        readNotWriteIn = 1'($urandom_range(0, 1));
        addressIn      = $urandom();
        writeDataIn    = $urandom();
        byteEnablesIn  = 4'($urandom_range(0, 15));
      end
      gnt   = (r >= 1 + t.gd);
      bsy   = t.wr && r >= ma.B + 1 && r <= ma.B + t.busy;
      dvin  = !t.wr && r == ma.d;
      adin  = dvin ? t.rdata : $urandom();
      endin = !t.wr && r == ma.c;
      berr  = t.has_err && r == ma.B + t.e;
      @(negedge clock);
      if (rst_at >= 0 && r == rst_at + 1) begin
        chk("a_after_rst", obs_a, 64'd0);
        chk("b_after_rst", obs_b, 64'd0);
        chk("a_rdata_rst", {32'd0, rdata_a}, 64'd0);
        chk("b_rdata_rst", {32'd0, rdata_b}, 64'd0);
        shadow_a = '0;
        shadow_b = '0;
        @(posedge clock); #1;
        break;
      end
      chk($sformatf("a_cyc%0d", r), obs_a, exp_vec(t, ma, r));
      chk($sformatf("b_cyc%0d", r), obs_b, exp_vec(t, mb, r));
      if (r == 0) begin
        chk("a_rdata_hold", {32'd0, rdata_a}, {32'd0, shadow_a});
        chk("b_rdata_hold", {32'd0, rdata_b}, {32'd0, shadow_b});
      end
      if (r == ma.D) chk("a_rdata_done", {32'd0, rdata_a}, {32'd0, ra});
      if (r == mb.D) chk("b_rdata_done", {32'd0, rdata_b}, {32'd0, rb});
      @(posedge clock); #1;
    end
    if (rst_at < 0) begin
      shadow_a = ra;
      shadow_b = rb;
    end
    reset = 1'b0;
    idle_inputs();
    for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
      @(negedge clock);
      chk("a_idle", obs_a, 64'd0);
      chk("b_idle", obs_b, 64'd0);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("a_reset", obs_a, 64'd0);
    chk("b_reset", obs_b, 64'd0);
    chk("a_reset_rdata", {32'd0, rdata_a}, 64'd0);
    chk("b_reset_rdata", {32'd0, rdata_b}, 64'd0);
    shadow_a = '0;
    shadow_b = '0;
    @(posedge clock); #1;

    run_txn(mk_txn(1, 0, 0, 0, 0, 0, 0, 32'h4000_0010, 32'hDEAD_BEEF, 32'h0, 4'hF), -1);
    run_txn(mk_txn(0, 3, 0, 1, 0, 0, 0, 32'h4000_0020, 32'h0, 32'h1234_5678, 4'hF), -1);
    run_txn(mk_txn(1, 0, 4, 0, 0, 0, 0, 32'h4000_0030, 32'hCAFE_F00D, 32'h0, 4'h3), -1);
    run_txn(mk_txn(0, 1, 0, 3, 0, 1, 2, 32'h4000_0040, 32'h0, 32'h55AA_55AA, 4'hF), -1);
    run_txn(mk_txn(0, 0, 0, 100000, 0, 0, 0, 32'h4000_0050, 32'h0, 32'h0BAD_F00D, 4'hF), -1);
    run_txn(mk_txn(0, 0, 0, 0, 2, 0, 0, 32'h4000_0054, 32'h0, 32'hA5A5_0001, 4'hF), -1);
    run_txn(mk_txn(1, 0, 10, 0, 0, 0, 0, 32'h4000_0060, 32'h1357_2468, 32'h0, 4'hF), 3);
    run_txn(mk_txn(1, 2, 1, 0, 0, 0, 0, 32'h4000_0070, 32'h2468_1357, 32'h0, 4'hC), -1);

    for (int i = 0; i < 40; i++) run_txn(rand_txn(), -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uncached_bus_master.md
Name: uncached_bus_master

Overview:
- Single-beat bus master used by the memory stage for all uncached loads and stores (address bit 30 set, or cache disabled).
- Accepts one request from the memory stage and arbitrates for the shared bus.
- Runs one read or write transaction and returns read data or an error, with a one-cycle done pulse.
- The memory stage holds its stall asserted from request until done.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles allowed from the begin beat to completion before the transaction is aborted as an error (range 1..255).

Ports:
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- startIn  in  1  request pulse from memory stage; sampled only in IDLE
- readNotWriteIn  in  1  1 = load, 0 = store
- addressIn  in  32  word-aligned byte address
- writeDataIn  in  32  store data, already lane-aligned
- byteEnablesIn  in  4  active lanes
- busyOut  out  1  high in every state except IDLE
- doneOut  out  1  one-cycle completion pulse
- errorOut  out  1  high together with doneOut when the transaction failed
- readDataOut  out  32  captured load data; valid from doneOut and held until the next capture
- requestBus  out  1  bus request to arbiter
- busAccessGranted  in  1  grant from arbiter
- beginTransactionOut  out  1  begin beat
- addressDataOut  out  32  multiplexed address/data
- byteEnablesOut  out  4  lanes; driven during the begin beat only
- readNotWriteOut  out  1  driven during the begin beat only
- burstSizeOut  out  8  always 0 (single beat) during the begin beat
- dataValidOut  out  1  write data valid
- endTransactionOut  out  1  master end beat
- busyIn  in  1  slave back-pressure on write data
- dataValidIn  in  1  slave read data valid
- addressDataIn  in  32  slave read data
- endTransactionIn  in  1  slave end beat (reads)
- busErrorIn  in  1  bus error

Behaviour:
- All bus outputs are 0 when not actively driven, because the bus is wired-OR.
- Reset forces state IDLE and clears all outputs, readDataOut and the timeout counter. Reset mid-transaction abandons it; no end beat is issued.
- IDLE:
  - On startIn=1, latch address, data, byte enables and read/write direction; go to REQUEST.
  - startIn in any other state is ignored.
- REQUEST: requestBus=1; on busAccessGranted=1 go to BEGIN.
- requestBus stays 1 from REQUEST until the cycle after the last driven beat, i.e. through END/ERROR inclusive.
- BEGIN (exactly 1 cycle):
  - beginTransactionOut=1, addressDataOut=address, byteEnablesOut, readNotWriteOut and burstSizeOut=0 are driven.
  - Clear the timeout counter.
  - Next state: WRITE_DATA for a store, WAIT_READ for a load.
- WRITE_DATA:
  - addressDataOut=write data and dataValidOut=1.
  - The beat is accepted in the first cycle with busyIn=0; then go to END.
  - While busyIn=1, hold data and dataValidOut.
- END (1 cycle): endTransactionOut=1, then go to DONE.
- WAIT_READ:
  - On dataValidIn=1, capture addressDataIn into readDataOut.
  - If endTransactionIn=1 in the same cycle, go to DONE; otherwise go to WAIT_END.
  - endTransactionIn without a prior dataValidIn is treated as an error.
- WAIT_END: on endTransactionIn=1 go to DONE.
- DONE (1 cycle): doneOut=1, busyOut=1; next state IDLE.
- Errors:
  - busErrorIn=1 in BEGIN, WRITE_DATA, WAIT_READ or WAIT_END goes to ERROR.
  - So does the timeout counter, which increments every cycle after BEGIN and fires on reaching TIMEOUT_CYCLES.
  - Error takes priority over simultaneous dataValidIn/endTransactionIn.
- ERROR (1 cycle):
  - endTransactionOut=1 only if the error was a timeout; on busErrorIn the bus is released without an end beat.
  - doneOut=1 and errorOut=1; readDataOut is unchanged; next state IDLE.
- Latency with immediate grant and zero wait states:
  - store: start → done = 5 cycles (REQUEST, BEGIN, WRITE_DATA, END, DONE);
  - load with data and end in the first WAIT_READ cycle: 4 cycles.

Test Plan:
- Store 0xDEADBEEF to 0x40000010 with BE=0xF, grant immediate, busyIn=0 → begin beat carries addr 0x40000010, burst 0, rnw 0; next cycle data 0xDEADBEEF with dataValidOut; then endTransactionOut; doneOut 5 cycles after start, errorOut=0.
- Load from 0x40000020, grant delayed 3 cycles, slave gives dataValidIn+endTransactionIn with 0x12345678 two cycles after begin → requestBus held throughout; readDataOut=0x12345678 at doneOut; errorOut=0.
- Store with busyIn=1 for 4 cycles → data and dataValidOut held constant for 5 cycles, END follows the first busyIn=0 cycle.
- Load where slave asserts busErrorIn in WAIT_READ → doneOut=errorOut=1 next cycle, no endTransactionOut, readDataOut keeps its previous value, busyOut=0 after.
- Load with TIMEOUT_CYCLES=4 and silent slave → endTransactionOut and doneOut+errorOut 4 cycles after begin; a second startIn during the transaction is ignored.
- Reset asserted in WRITE_DATA → all outputs 0 next cycle, state IDLE, new startIn accepted normally.
